ups_axi4l_regs: RTL

- AXI4-Lite responder (slave) register bank for the UPS control path.
- Terminates the ca4l_* channel driven by the PS/host master.
- Holds mode, DAC setpoints, valve and sequencer counts; generates start/stop strobes; returns sequencer status.
- Sits between the Zynq AXI GP port and the UPS sequencer/DAC logic.

---
 rtl/ups_axi4l_regs_if.sv | 47 ++++
 rtl/ups_axi4l_regs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ups_axi4l_regs_if.sv
// AXI4-Lite channel bundle between the PS/host master and the UPS register bank.
interface ups_axi4l_regs_if #(
  parameter int unsigned ADDR_W = 32
);

  // Write address channel
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  // Write data channel
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;

  // Write response channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  // Read address channel
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  // Read data channel
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ups_axi4l_regs.sv
// AXI4-Lite register bank for the UPS control path: mode, DAC setpoints,
// valve, sequencer counts, start/stop strobes and sequencer status readback.
module ups_axi4l_regs #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned USE_WSTRB = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             fclk,
  input  logic             rst,
  ups_axi4l_regs_if.slave  ca4l,
  output logic [1:0]       mode,
  output logic [11:0]      dac0,
  output logic [11:0]      dac1,
  output logic             dac0_upd,
  output logic             dac1_upd,
  output logic             valve,
  output logic [CNT_W-1:0] loops,
  output logic [CNT_W-1:0] pre_cnt,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] post_cnt,
  output logic             start_stb,
  output logic             stop_stb,
  input  logic [31:0]      status
);

  localparam int unsigned DEC_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  localparam logic [DEC_W-1:0] A_MODE   = 8'h00;
  localparam logic [DEC_W-1:0] A_DAC0   = 8'h04;
  localparam logic [DEC_W-1:0] A_DAC1   = 8'h08;
  localparam logic [DEC_W-1:0] A_VALVE  = 8'h0C;
  localparam logic [DEC_W-1:0] A_LOOPS  = 8'h10;
  localparam logic [DEC_W-1:0] A_PRE    = 8'h14;
  localparam logic [DEC_W-1:0] A_RUN    = 8'h18;
  localparam logic [DEC_W-1:0] A_POST   = 8'h1C;
  localparam logic [DEC_W-1:0] A_START  = 8'h20;
  localparam logic [DEC_W-1:0] A_STOP   = 8'h24;
  localparam logic [DEC_W-1:0] A_STATUS = 8'h40;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  w_state_t          w_state_q, w_state_d;
  r_state_t          r_state_q, r_state_d;
  logic              awready_d, wready_d, bvalid_d;
  logic              arready_d, rvalid_d;
  logic [DEC_W-1:0]  w_addr_q;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merge;
  logic [DEC_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic              unused_bits;

  assign aw_hs = ca4l.awvalid & ca4l.awready;
  assign w_hs  = ca4l.wvalid  & ca4l.wready;
  assign b_hs  = ca4l.bvalid  & ca4l.bready;
  assign ar_hs = ca4l.arvalid & ca4l.arready;
  assign r_hs  = ca4l.rvalid  & ca4l.rready;

  // Only addr[7:0] is decoded; protection bits are not used.
  assign unused_bits = ^{ca4l.awprot, ca4l.arprot, ca4l.wstrb,
                         ca4l.awaddr[ADDR_W-1:DEC_W], ca4l.araddr[ADDR_W-1:DEC_W]};

  // Write FSM next state; ready/valid are registered copies of the next state.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs)  w_state_d = W_RESP;
      W_RESP:  if (b_hs)  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM state and handshake outputs.
  always_ff @(posedge fclk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      ca4l.awready <= 1'b1;
      ca4l.wready  <= 1'b0;
      ca4l.bvalid  <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      ca4l.awready <= awready_d;
      ca4l.wready  <= wready_d;
      ca4l.bvalid  <= bvalid_d;
    end
  end

  // Writable window is word-aligned 0x00..0x24; everything else is an error.
  assign wr_ok = (w_addr_q[1:0] == 2'b00) && (w_addr_q <= A_STOP);

  // Current contents of the addressed register, used to keep unstrobed lanes.
  always_comb begin
    wr_old = '0;
    case (w_addr_q)
      A_MODE:  wr_old = DATA_W'(mode);
      A_DAC0:  wr_old = DATA_W'(dac0);
      A_DAC1:  wr_old = DATA_W'(dac1);
      A_VALVE: wr_old = DATA_W'(valve);
      A_LOOPS: wr_old = DATA_W'(loops);
      A_PRE:   wr_old = DATA_W'(pre_cnt);
      A_RUN:   wr_old = DATA_W'(run_cnt);
      A_POST:  wr_old = DATA_W'(post_cnt);
      default: wr_old = '0;
    endcase
  end

  // Byte-lane merge of write data with the old register value.
  always_comb begin
    wr_merge = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if ((USE_WSTRB == 0) || ca4l.wstrb[i])
        wr_merge[8*i +: 8] = ca4l.wdata[8*i +: 8];
      else
        wr_merge[8*i +: 8] = wr_old[8*i +: 8];
    end
  end

  // Address latch, write response and register commit on the W handshake.
  always_ff @(posedge fclk) begin
    if (rst) begin
      w_addr_q   <= '0;
      ca4l.bresp <= RESP_OKAY;
      mode       <= '0;
      dac0       <= '0;
      dac1       <= '0;
      valve      <= 1'b0;
      loops      <= '0;
      pre_cnt    <= '0;
      run_cnt    <= '0;
      post_cnt   <= '0;
      dac0_upd   <= 1'b0;
      dac1_upd   <= 1'b0;
      start_stb  <= 1'b0;
      stop_stb   <= 1'b0;
    end else begin
      dac0_upd  <= 1'b0;
      dac1_upd  <= 1'b0;
      start_stb <= 1'b0;
      stop_stb  <= 1'b0;
      if (aw_hs) w_addr_q <= ca4l.awaddr[DEC_W-1:0];
      if (w_hs) begin
        ca4l.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          case (w_addr_q)
            A_MODE:  mode     <= wr_merge[1:0];
            A_DAC0:  begin dac0 <= wr_merge[11:0]; dac0_upd <= 1'b1; end
            A_DAC1:  begin dac1 <= wr_merge[11:0]; dac1_upd <= 1'b1; end
            A_VALVE: valve    <= wr_merge[0];
            A_LOOPS: loops    <= wr_merge[CNT_W-1:0];
            A_PRE:   pre_cnt  <= wr_merge[CNT_W-1:0];
            A_RUN:   run_cnt  <= wr_merge[CNT_W-1:0];
            A_POST:  post_cnt <= wr_merge[CNT_W-1:0];
            A_START: start_stb <= 1'b1;
            A_STOP:  stop_stb  <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Read decode from the live AR address; status is sampled at the AR edge.
  assign rd_addr = ca4l.araddr[DEC_W-1:0];

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (rd_addr[1:0] == 2'b00) begin
      rd_resp = RESP_OKAY;
      case (rd_addr)
        A_MODE:   rd_data = DATA_W'(mode);
        A_DAC0:   rd_data = DATA_W'(dac0);
        A_DAC1:   rd_data = DATA_W'(dac1);
        A_VALVE:  rd_data = DATA_W'(valve);
        A_LOOPS:  rd_data = DATA_W'(loops);
        A_PRE:    rd_data = DATA_W'(pre_cnt);
        A_RUN:    rd_data = DATA_W'(run_cnt);
        A_POST:   rd_data = DATA_W'(post_cnt);
        A_START:  rd_data = '0;
        A_STOP:   rd_data = '0;
        A_STATUS: rd_data = status;
        default:  rd_resp = RESP_SLVERR;
      endcase
    end
  end

  // Read FSM next state; arready/rvalid are registered copies of the next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read FSM state, handshake outputs and read data capture.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state_q    <= R_IDLE;
      ca4l.arready <= 1'b1;
      ca4l.rvalid  <= 1'b0;
      ca4l.rdata   <= '0;
      ca4l.rresp   <= RESP_OKAY;
    end else begin
      r_state_q    <= r_state_d;
      ca4l.arready <= arready_d;
      ca4l.rvalid  <= rvalid_d;
      if (ar_hs) begin
        ca4l.rdata <= rd_data;
        ca4l.rresp <= rd_resp;
      end
    end
  end

endmodule
